// File: rtl/state_dump_pkg.sv
// rtl/state_dump_pkg.sv - shared FSM states and frame geometry for the state dump block
package state_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_REG,
    ST_MEM
  } state_t;

  localparam int HDR_WORDS   = 4;
  localparam int NUM_REGS    = 32;
  localparam int DM_WORDS    = 8;
  localparam int FRAME_WORDS = HDR_WORDS + NUM_REGS + DM_WORDS;

  localparam int IDX_W = 6;
  typedef logic [IDX_W-1:0] idx_t;

  // Index of the last word of each section
  localparam idx_t IDX_HDR_LAST = idx_t'(HDR_WORDS - 1);
  localparam idx_t IDX_REG_LAST = idx_t'(HDR_WORDS + NUM_REGS - 1);
  localparam idx_t IDX_LAST     = idx_t'(FRAME_WORDS - 1);

endpackage

// File: rtl/state_dump_if.sv
// rtl/state_dump_if.sv - dump word stream between the state dump block and its sink
interface state_dump_if;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/state_dump_event_counter.sv
// rtl/state_dump_event_counter.sv - 32-bit wrapping event counter with enable
module event_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  // Unconditional write keeps the register updated every edge, enable adds 0 or 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count + {31'd0, en};
  end

endmodule

// File: rtl/state_dump.sv
// rtl/state_dump.sv - snapshots CPU counters, PC, register file and low data memory
// into a 44-word stream frame on request
module state_dump
  import state_dump_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [31:0]  pc_i,
  input  logic         trig_i,
  output logic [4:0]   rf_addr_o,
  input  logic [31:0]  rf_data_i,
  output logic [4:0]   dm_addr_o,
  input  logic [31:0]  dm_data_i,
  output logic         busy_o,
  state_dump_if.master dump
);

  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  event_counter u_cycle_cnt (.clk(clk_i), .rst_n(rst_n_i), .en(start_i), .count(cycle_cnt));
  event_counter u_stall_cnt (.clk(clk_i), .rst_n(rst_n_i), .en(stall_i), .count(stall_cnt));
  event_counter u_flush_cnt (.clk(clk_i), .rst_n(rst_n_i), .en(flush_i), .count(flush_cnt));

  state_t      state;
  idx_t        idx;
  logic [31:0] snap_stall, snap_flush, snap_pc;
  logic [31:0] dout_q;
  logic        valid_q, last_q, busy_q;
  logic [4:0]  rf_addr_q, dm_addr_q;

  idx_t        nxt_idx;
  logic [31:0] nxt_word;
  state_t      nxt_state;
  logic [4:0]  nxt_rf_addr, nxt_dm_addr;

  // What the output register holds after the next transfer, and which
  // address must be presented so the word after that is ready in time
  always_comb begin
    nxt_idx     = idx + idx_t'(1);
    nxt_word    = '0;
    nxt_state   = ST_MEM;
    nxt_rf_addr = '0;
    nxt_dm_addr = '0;
    if      (nxt_idx == idx_t'(1))    nxt_word = snap_stall;
    else if (nxt_idx == idx_t'(2))    nxt_word = snap_flush;
    else if (nxt_idx == IDX_HDR_LAST) nxt_word = snap_pc;
    else if (nxt_idx <= IDX_REG_LAST) nxt_word = rf_data_i;
    else                              nxt_word = dm_data_i;
    if      (nxt_idx < IDX_HDR_LAST)  nxt_state = ST_HDR;
    else if (nxt_idx < IDX_REG_LAST)  nxt_state = ST_REG;
    if (nxt_state == ST_REG)
      nxt_rf_addr = 5'(nxt_idx - IDX_HDR_LAST);
    if (nxt_state == ST_MEM && nxt_idx != IDX_LAST)
      nxt_dm_addr = {3'(nxt_idx - IDX_REG_LAST), 2'b00};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap_stall <= '0;
      snap_flush <= '0;
      snap_pc    <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      rf_addr_q  <= '0;
      dm_addr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_i) begin
            // Counter outputs still hold their pre-increment values on this edge
            snap_stall <= stall_cnt;
            snap_flush <= flush_cnt;
            snap_pc    <= pc_i;
            dout_q     <= cycle_cnt;
            valid_q    <= 1'b1;
            last_q     <= 1'b0;
            busy_q     <= 1'b1;
            idx        <= '0;
            state      <= ST_HDR;
          end
        end
        default: begin
          if (valid_q && dump.dout_ready) begin
            if (last_q) begin
              state     <= ST_IDLE;
              idx       <= '0;
              dout_q    <= '0;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              busy_q    <= 1'b0;
              rf_addr_q <= '0;
              dm_addr_q <= '0;
            end else begin
              idx       <= nxt_idx;
              dout_q    <= nxt_word;
              last_q    <= (nxt_idx == IDX_LAST);
              state     <= nxt_state;
              rf_addr_q <= nxt_rf_addr;
              dm_addr_q <= nxt_dm_addr;
            end
          end
        end
      endcase
    end
  end

  assign dump.dout       = dout_q;
  assign dump.dout_valid = valid_q;
  assign dump.dout_last  = last_q;
  assign busy_o          = busy_q;
  assign rf_addr_o       = rf_addr_q;
  assign dm_addr_o       = dm_addr_q;

endmodule

// File: tb/tb_state_dump.sv
// tb/tb_state_dump.sv - self-checking bench for state_dump against a frame-level model
module tb_state_dump;
  import state_dump_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i, start_i, stall_i, flush_i, trig_i;
  logic [31:0] pc_i, rf_data_i, dm_data_i;
  logic [4:0]  rf_addr_o, dm_addr_o;
  logic        busy_o;

  state_dump_if dump_bus ();

  state_dump dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .pc_i      (pc_i),
    .trig_i    (trig_i),
    .rf_addr_o (rf_addr_o),
    .rf_data_i (rf_data_i),
    .dm_addr_o (dm_addr_o),
    .dm_data_i (dm_data_i),
    .busy_o    (busy_o),
    .dump      (dump_bus)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] rf  [32];
  logic [7:0]  mem [32];

  assign rf_data_i = rf[rf_addr_o];
  assign dm_data_i = {mem[5'(dm_addr_o + 5'd3)], mem[5'(dm_addr_o + 5'd2)],
                      mem[5'(dm_addr_o + 5'd1)], mem[dm_addr_o]};

  logic [31:0] m_cyc, m_stall, m_flush;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        noise = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model counts whatever inputs were applied to that edge
  task automatic tick();
    @(posedge clk_i);
    if (!rst_n_i) begin
      m_cyc = '0; m_stall = '0; m_flush = '0;
    end else begin
      m_cyc   = m_cyc   + 32'(start_i);
      m_stall = m_stall + 32'(stall_i);
      m_flush = m_flush + 32'(flush_i);
    end
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(dump_bus.dout_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_dout"},  dump_bus.dout, 32'd0);
    chk({tag, "_last"},  32'(dump_bus.dout_last), 32'd0);
    chk({tag, "_addr"},  {22'd0, rf_addr_o, dm_addr_o}, 32'd0);
  endtask

  // mode: 0 ready always high, 1 ready toggling 1/0, 2 random ready
  task automatic run_frame(input int mode, input int trig_idx, input int abort_idx,
                           input logic [31:0] pc);
    logic [31:0] exp [FRAME_WORDS];
    int   got, cyc;
    logic rdy;
    exp[0] = m_cyc;
    exp[1] = m_stall;
    exp[2] = m_flush;
    exp[3] = pc;
    for (int i = 0; i < NUM_REGS; i++) exp[HDR_WORDS + i] = rf[i];
    for (int j = 0; j < DM_WORDS; j++)
      exp[HDR_WORDS + NUM_REGS + j] = {mem[4*j+3], mem[4*j+2], mem[4*j+1], mem[4*j]};
    pc_i   = pc;
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    got = 0;
    cyc = 0;
    while (got < FRAME_WORDS && cyc < 400) begin
      chk("valid", 32'(dump_bus.dout_valid), 32'd1);
      chk("busy",  32'(busy_o), 32'd1);
      chk($sformatf("word%0d", got), dump_bus.dout, exp[got]);
      chk("last", 32'(dump_bus.dout_last), 32'(got == FRAME_WORDS - 1));
      if (got == abort_idx) begin
        #2 rst_n_i = 1'b0;
        #1;
        m_cyc = '0; m_stall = '0; m_flush = '0;
        chk_idle("abort");
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dump_bus.dout_ready = rdy;
      trig_i = (got == trig_idx);
      if (noise) begin
        start_i = 1'($urandom_range(0, 1));
        stall_i = 1'($urandom_range(0, 1));
        flush_i = 1'($urandom_range(0, 1));
      end
      tick();
      trig_i = 1'b0;
      if (rdy) got++;
      cyc++;
    end
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    dump_bus.dout_ready = 1'b0;
    chk("frame_words", 32'(got), 32'(FRAME_WORDS));
    if (mode == 0) chk("frame_cycles", 32'(cyc), 32'd44);
    if (mode == 1) chk("frame_cycles", 32'(cyc), 32'd87);
    chk_idle("post_frame");
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; trig_i = 1'b0;
    pc_i = '0; dump_bus.dout_ready = 1'b0;
    m_cyc = '0; m_stall = '0; m_flush = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    mem[0] = 8'd5;
    tick();
    tick();
    chk_idle("reset");
    rst_n_i = 1'b1;

    // Known counters and register/memory image, full-rate sink
    start_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      stall_i = (k == 2 || k == 5);
      flush_i = (k == 7);
      tick();
    end
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    run_frame(0, -1, -1, 32'h20);

    // Toggling ready with counters moving underneath the dump
    randomize_state();
    noise = 1'b1;
    run_frame(1, -1, -1, $urandom);

    // Triggers at word 10 and at last-word acceptance are dropped; the next
    // cycle's trigger starts a fresh frame straight away
    randomize_state();
    run_frame(0, 10, -1, $urandom);
    chk("no_retrigger_busy", 32'(busy_o), 32'd0);
    run_frame(0, 43, -1, $urandom);
    run_frame(2, -1, -1, $urandom);

    // Reset in the middle of a frame, then a clean frame from index 0
    randomize_state();
    run_frame(0, -1, 20, $urandom);
    tick();
    rst_n_i = 1'b1;
    start_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    start_i = 1'b0;
    run_frame(2, -1, -1, $urandom);

    // Cycle counter wrap
    noise = 1'b0;
    force dut.u_cycle_cnt.count = 32'hFFFF_FFFE;
    tick();
    release dut.u_cycle_cnt.count;
    m_cyc = 32'hFFFF_FFFE;
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    start_i = 1'b0;
    chk("wrap_model", m_cyc, 32'd1);
    run_frame(0, -1, -1, 32'h0000_1000);

    // Randomized frames
    noise = 1'b1;
    for (int f = 0; f < 3; f++) begin
      randomize_state();
      run_frame(2, -1, -1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
